// File: rtl/uartlite_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uartlite_core                                                |
// | Description : UART-lite with RX/TX engines, RX/TX FIFOs, a 4-word register |
// |               map (RXFIFO, TXFIFO, STAT, CTRL) and a level interrupt.      |
// | Ports       : IO_Clk_I/IO_Rst_I  clock, synchronous active-high reset      |
// |               Reg_*              CPU register access, registered read data |
// |               IO_Irq_O           IntrEn & (RxValid | TxIrqPend)            |
// |               IO_Rx_I/IO_Tx_O    serial line in (async) / out (idle high)  |
// | Option      : UARTLITE_PARITY_EN adds a parity bit, CTRL[2] = ParityOdd    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uartlite_core #(
   parameter int Param_ClkFreq     = 10_000_000,
   parameter int Param_BaudRate    = 115200,
   parameter int Param_PayloadBits = 8,
   parameter int Param_FifoDepth   = 16
) (
   input  logic        IO_Clk_I,
   input  logic        IO_Rst_I,
   input  logic [1:0]  Reg_Addr_I,
   input  logic        Reg_Wr_I,
   input  logic        Reg_Rd_I,
   input  logic [31:0] Reg_WData_I,
   output logic [31:0] Reg_RData_O,
   output logic        IO_Irq_O,
   input  logic        IO_Rx_I,
   output logic        IO_Tx_O
);
   localparam int DIV = Param_ClkFreq / Param_BaudRate;
   localparam int W   = Param_PayloadBits;
   localparam int AW  = $clog2(Param_FifoDepth);
   localparam int CW  = $clog2(DIV);
   localparam int BW  = $clog2(W);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] C_CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [BW-1:0] C_BIT_LAST = BW'(W - 1);

   generate
      if ((DIV < 8) || ((Param_ClkFreq % Param_BaudRate) != 0)) begin : g_bad_div
         $error("uartlite_core: clock/baud ratio must be an integer >= 8");
      end
      if ((W < 5) || (W > 8) || (Param_FifoDepth < 2) || ((1 << AW) != Param_FifoDepth)) begin : g_bad_cfg
         $error("uartlite_core: payload must be 5..8, FIFO depth a power of 2 >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
`ifdef UARTLITE_PARITY_EN
      RX_PARITY = 3'd3,
`endif
      RX_STOP = 3'd4, RX_WAIT = 3'd5
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
`ifdef UARTLITE_PARITY_EN
      TX_PARITY = 3'd3,
`endif
      TX_STOP = 3'd4
   } tx_state_t;

   // ---------------- state ----------------
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [BW-1:0] rx_bit_q, rx_bit_d;
   logic [W-1:0]  rx_shift_q, rx_shift_d;
   logic          rx_par_bad_q, rx_par_bad_d;
   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [BW-1:0] tx_bit_q, tx_bit_d;
   logic [W-1:0]  tx_shift_q, tx_shift_d;
   logic          tx_line_q, tx_line_d;
   logic [AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [W-1:0]  rx_mem [Param_FifoDepth];
   logic [W-1:0]  tx_mem [Param_FifoDepth];
   logic          intr_en_q, intr_en_d, overrun_q, overrun_d;
   logic          frame_err_q, frame_err_d, par_err_q, par_err_d;
   logic          tx_irq_pend_q, tx_irq_pend_d, irq_q, irq_d;
   logic [31:0]   rdata_q, rdata_d;
`ifdef UARTLITE_PARITY_EN
   logic          par_odd_q, par_odd_d;
   logic          tx_par_q, tx_par_d;
`endif

   // ---------------- combinational nets ----------------
   logic rx_empty, rx_full, tx_empty, tx_full;
   logic rd_rx, rd_stat, wr_tx, wr_ctrl;
   logic rx_pop, rx_push, rx_push_req, tx_push, tx_pop;
   logic rx_frame_set, rx_par_set, tx_irq_set;
   logic [W-1:0] tx_head;
   logic unused_wdata;

   assign rx_empty = (rx_wr_q == rx_rd_q);
   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
   assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
   assign rd_rx    = Reg_Rd_I && (Reg_Addr_I == 2'd0);
   assign wr_tx    = Reg_Wr_I && (Reg_Addr_I == 2'd1);
   assign rd_stat  = Reg_Rd_I && (Reg_Addr_I == 2'd2);
   assign wr_ctrl  = Reg_Wr_I && (Reg_Addr_I == 2'd3);
   assign rx_pop   = rd_rx && !rx_empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign rx_push  = rx_push_req && (!rx_full || rx_pop);
   assign tx_push  = wr_tx && !tx_full;
   assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];
   assign unused_wdata = ^Reg_WData_I;

   // ---------------- RX engine ----------------
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q + 1'b1;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_bad_d = rx_par_bad_q;
      rx_push_req  = 1'b0;
      rx_frame_set = 1'b0;
      rx_par_set   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
         end
         RX_START: if (rx_cnt_q == C_CNT_HALF) begin
            // Line back high at mid start bit means a glitch, not a frame.
            rx_cnt_d     = '0;
            rx_bit_d     = '0;
            rx_par_bad_d = 1'b0;
            rx_state_d   = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == C_CNT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s2_q, rx_shift_q[W-1:1]};
            rx_bit_d   = rx_bit_q + 1'b1;
`ifdef UARTLITE_PARITY_EN
            if (rx_bit_q == C_BIT_LAST) rx_state_d = RX_PARITY;
`else
            if (rx_bit_q == C_BIT_LAST) rx_state_d = RX_STOP;
`endif
         end
`ifdef UARTLITE_PARITY_EN
         RX_PARITY: if (rx_cnt_q == C_CNT_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_STOP;
            if (rx_s2_q != (^rx_shift_q ^ par_odd_q)) begin
               rx_par_bad_d = 1'b1;
               rx_par_set   = 1'b1;
            end
         end
`endif
         RX_STOP: if (rx_cnt_q == C_CNT_LAST) begin
            rx_cnt_d = '0;
            if (rx_s2_q) begin
               rx_push_req = !rx_par_bad_q;
               rx_state_d  = RX_IDLE;
            end else begin
               rx_frame_set = 1'b1;
               rx_state_d   = RX_WAIT;
            end
         end
         RX_WAIT: begin
            rx_cnt_d = '0;
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- TX engine ----------------
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      tx_irq_set = 1'b0;
`ifdef UARTLITE_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_state_d = TX_START;
`ifdef UARTLITE_PARITY_EN
               tx_par_d   = ^tx_head ^ par_odd_q;
`endif
            end
         end
         TX_START: if (tx_cnt_q == C_CNT_LAST) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
         end
         TX_DATA: if (tx_cnt_q == C_CNT_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == C_BIT_LAST) begin
`ifdef UARTLITE_PARITY_EN
               tx_state_d = TX_PARITY;
`else
               tx_state_d = TX_STOP;
`endif
            end else begin
               tx_shift_d = {1'b0, tx_shift_q[W-1:1]};
               tx_bit_d   = tx_bit_q + 1'b1;
            end
         end
`ifdef UARTLITE_PARITY_EN
         TX_PARITY: if (tx_cnt_q == C_CNT_LAST) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_STOP;
         end
`endif
         TX_STOP: if (tx_cnt_q == C_CNT_LAST) begin
            tx_cnt_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_state_d = TX_START;
`ifdef UARTLITE_PARITY_EN
               tx_par_d   = ^tx_head ^ par_odd_q;
`endif
            end else begin
               tx_state_d = TX_IDLE;
               tx_irq_set = 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      // The line flop follows the next state so each bit lasts exactly DIV cycles.
      case (tx_state_d)
         TX_START:  tx_line_d = 1'b0;
         TX_DATA:   tx_line_d = tx_shift_d[0];
`ifdef UARTLITE_PARITY_EN
         TX_PARITY: tx_line_d = tx_par_d;
`endif
         default:   tx_line_d = 1'b1;
      endcase
   end

   // ---------------- FIFOs and registers ----------------
   always_comb begin
      rx_wr_d       = rx_wr_q;
      rx_rd_d       = rx_rd_q;
      tx_wr_d       = tx_wr_q;
      tx_rd_d       = tx_rd_q;
      intr_en_d     = intr_en_q;
      overrun_d     = overrun_q;
      frame_err_d   = frame_err_q;
      par_err_d     = par_err_q;
      tx_irq_pend_d = tx_irq_pend_q;
      rdata_d       = rdata_q;
`ifdef UARTLITE_PARITY_EN
      par_odd_d     = par_odd_q;
`endif
      if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
      if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
      if (rd_stat) begin
         overrun_d     = 1'b0;
         frame_err_d   = 1'b0;
         par_err_d     = 1'b0;
         tx_irq_pend_d = 1'b0;
      end
      // New events win over a coincident clear-on-read so none are lost.
      if (rx_push_req && rx_full && !rx_pop) overrun_d = 1'b1;
      if (rx_frame_set) frame_err_d   = 1'b1;
      if (rx_par_set)   par_err_d     = 1'b1;
      if (tx_irq_set)   tx_irq_pend_d = 1'b1;
      if (wr_ctrl) begin
         intr_en_d = Reg_WData_I[4];
`ifdef UARTLITE_PARITY_EN
         par_odd_d = Reg_WData_I[2];
`endif
         if (Reg_WData_I[0]) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
         end
         if (Reg_WData_I[1]) begin
            rx_wr_d = '0;
            rx_rd_d = '0;
         end
      end
      if (Reg_Rd_I) begin
         case (Reg_Addr_I)
            2'd0:    rdata_d = rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_q[AW-1:0]]);
            2'd2:    rdata_d = 32'({par_err_q, frame_err_q, overrun_q, intr_en_q,
                                    tx_full, tx_empty, rx_full, !rx_empty});
            default: rdata_d = 32'd0;
         endcase
      end
      irq_d = intr_en_q & (!rx_empty | tx_irq_pend_q);
   end

   always_ff @(posedge IO_Clk_I) begin
      if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
      if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= Reg_WData_I[W-1:0];
   end

   always_ff @(posedge IO_Clk_I) begin
      if (IO_Rst_I) begin
         rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
         rx_state_q <= RX_IDLE;  rx_cnt_q <= '0;  rx_bit_q <= '0;
         rx_shift_q <= '0;  rx_par_bad_q <= 1'b0;
         tx_state_q <= TX_IDLE;  tx_cnt_q <= '0;  tx_bit_q <= '0;
         tx_shift_q <= '0;  tx_line_q <= 1'b1;
         rx_wr_q <= '0;  rx_rd_q <= '0;  tx_wr_q <= '0;  tx_rd_q <= '0;
         intr_en_q <= 1'b0;  overrun_q <= 1'b0;  frame_err_q <= 1'b0;
         par_err_q <= 1'b0;  tx_irq_pend_q <= 1'b0;  irq_q <= 1'b0;
         rdata_q <= '0;
`ifdef UARTLITE_PARITY_EN
         par_odd_q <= 1'b0;  tx_par_q <= 1'b0;
`endif
      end else begin
         rx_s1_q <= IO_Rx_I;  rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_s2_q;
         rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;
         rx_shift_q <= rx_shift_d;  rx_par_bad_q <= rx_par_bad_d;
         tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;
         tx_shift_q <= tx_shift_d;  tx_line_q <= tx_line_d;
         rx_wr_q <= rx_wr_d;  rx_rd_q <= rx_rd_d;  tx_wr_q <= tx_wr_d;  tx_rd_q <= tx_rd_d;
         intr_en_q <= intr_en_d;  overrun_q <= overrun_d;  frame_err_q <= frame_err_d;
         par_err_q <= par_err_d;  tx_irq_pend_q <= tx_irq_pend_d;  irq_q <= irq_d;
         rdata_q <= rdata_d;
`ifdef UARTLITE_PARITY_EN
         par_odd_q <= par_odd_d;  tx_par_q <= tx_par_d;
`endif
      end
   end

   assign Reg_RData_O = rdata_q;
   assign IO_Irq_O    = irq_q;
   assign IO_Tx_O     = tx_line_q;
endmodule
`default_nettype wire

// File: tb/tb_uartlite_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uartlite_core                                             |
// | Description : Directed self-checking bench for uartlite_core at DIV=10.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uartlite_core;
   localparam int DIV = 10;
`ifdef UARTLITE_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irq;
   logic        tx_line;
   logic        rx_drv = 1'b1;
   logic        loop_en = 1'b0;
   logic        rx_line;
   int          checks = 0;
   int          errors = 0;
`ifdef UARTLITE_PARITY_EN
   logic        par_force = 1'b0;
   logic        par_val = 1'b0;
   logic        par_odd = 1'b0;
`endif

   assign rx_line = loop_en ? tx_line : rx_drv;

   always #5 clk = ~clk;

   uartlite_core #(
      .Param_ClkFreq(10_000_000), .Param_BaudRate(1_000_000),
      .Param_PayloadBits(8), .Param_FifoDepth(16)
   ) dut (
      .IO_Clk_I(clk), .IO_Rst_I(rst), .Reg_Addr_I(addr), .Reg_Wr_I(wr),
      .Reg_Rd_I(rd), .Reg_WData_I(wdata), .Reg_RData_O(rdata),
      .IO_Irq_O(irq), .IO_Rx_I(rx_line), .IO_Tx_O(tx_line)
   );

   task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0; wdata = 32'd0;
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
      addr = a; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = rdata;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      rx_drv = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = data[i];
         repeat (DIV) @(negedge clk);
      end
`ifdef UARTLITE_PARITY_EN
      rx_drv = par_force ? par_val : (^data ^ par_odd);
      repeat (DIV) @(negedge clk);
`endif
      rx_drv = stop_bit;
      repeat (DIV) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_line); end
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      reg_read(2'd2, v);
      checks++; if (v !== 32'h04) begin errors++; $display("FAIL reset_stat: got %h want 04", v); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_rxempty: got %h want 0", v); end
   endtask

   task automatic test_regmap();
      logic [31:0] v;
      reg_write(2'd0, 32'hFF);
      reg_write(2'd2, 32'hFF);
      reg_write(2'd3, 32'h10);
      reg_read(2'd2, v);
      checks++; if (v !== 32'h14) begin errors++; $display("FAIL map_stat_ie: got %h want 14", v); end
      reg_read(2'd3, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL map_ctrl_read: got %h want 0", v); end
      reg_read(2'd1, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL map_tx_read: got %h want 0", v); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL map_rx_wr_ignored: got %h want 0", v); end
      reg_write(2'd3, 32'h00);
      reg_read(2'd2, v);
      checks++; if (v !== 32'h04) begin errors++; $display("FAIL map_stat_ie_off: got %h want 04", v); end
   endtask

   task automatic test_tx_frame();
      logic [31:0] v;
      logic [FRAME-1:0] bits;
      int n;
      // Frame as sent in time order from bit 0: start, 0x55 LSB first, [parity], stop.
`ifdef UARTLITE_PARITY_EN
      bits = {1'b1, 1'b0, 8'h55, 1'b0};
`else
      bits = {1'b1, 8'h55, 1'b0};
`endif
      reg_write(2'd1, 32'h55);
      n = 0;
      while (tx_line !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL tx_start_timeout: tx %b want 0", tx_line); end
      for (int b = 0; b < FRAME; b++) begin
         for (int c = 0; c < DIV; c++) begin
            checks++;
            if (tx_line !== bits[b]) begin
               errors++; $display("FAIL tx_bit%0d_cyc%0d: got %b want %b", b, c, tx_line, bits[b]);
            end
            @(negedge clk);
         end
      end
      checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b want 1", tx_line); end
      reg_read(2'd2, v);
      checks++; if (v[2] !== 1'b1) begin errors++; $display("FAIL tx_empty_after: got %b want 1", v[2]); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      int n;
      loop_en = 1'b1;
      reg_write(2'd1, 32'hA3);
      reg_write(2'd1, 32'h5C);
      n = 0;
      while (tx_line !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL b2b_start_timeout: tx %b want 0", tx_line); end
      repeat (FRAME * DIV - 1) @(negedge clk);
      checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL b2b_stop: got %b want 1", tx_line); end
      @(negedge clk);
      checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b want 0", tx_line); end
      repeat (FRAME * DIV + 40) @(negedge clk);
      loop_en = 1'b0;
      reg_read(2'd0, v);
      checks++; if (v !== 32'hA3) begin errors++; $display("FAIL b2b_rx0: got %h want a3", v); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h5C) begin errors++; $display("FAIL b2b_rx1: got %h want 5c", v); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL b2b_rx_empty: got %h want 0", v); end
      reg_read(2'd2, v);
      checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL b2b_rxvalid: got %b want 0", v[0]); end
   endtask

   task automatic test_overrun();
      logic [31:0] v;
      for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
      repeat (5) @(negedge clk);
      reg_read(2'd2, v);
      checks++; if (v !== 32'h27) begin errors++; $display("FAIL ovr_stat1: got %h want 27", v); end
      reg_read(2'd2, v);
      checks++; if (v !== 32'h07) begin errors++; $display("FAIL ovr_stat2: got %h want 07", v); end
      for (int i = 0; i < 16; i++) begin
         reg_read(2'd0, v);
         checks++;
         if (v !== 32'(8'h10 + i)) begin
            errors++; $display("FAIL ovr_rx%0d: got %h want %h", i, v, 32'(8'h10 + i));
         end
      end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovr_17th_lost: got %h want 0", v); end
   endtask

   task automatic test_frame_err();
      logic [31:0] v;
      send_frame(8'h3C, 1'b0);
      repeat (20) @(negedge clk);
      reg_read(2'd2, v);
      checks++; if (v !== 32'h44) begin errors++; $display("FAIL ferr_stat: got %h want 44", v); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL ferr_rx_empty: got %h want 0", v); end
      rx_drv = 1'b0;
      @(negedge clk);
      rx_drv = 1'b1;
      repeat (FRAME * DIV + 20) @(negedge clk);
      reg_read(2'd2, v);
      checks++; if (v !== 32'h04) begin errors++; $display("FAIL glitch_stat: got %h want 04", v); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL glitch_rx: got %h want 0", v); end
   endtask

   task automatic test_irq();
      logic [31:0] v;
      reg_read(2'd2, v);
      reg_write(2'd3, 32'h10);
      repeat (3) @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
      send_frame(8'h7E, 1'b1);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b want 1", irq); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h7E) begin errors++; $display("FAIL irq_rxdata: got %h want 7e", v); end
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
      reg_write(2'd3, 32'h00);
   endtask

`ifdef UARTLITE_PARITY_EN
   task automatic test_parity();
      logic [31:0] v;
      reg_write(2'd3, 32'h04);
      par_odd = 1'b1; par_force = 1'b1; par_val = 1'b1;
      send_frame(8'h01, 1'b1);
      par_force = 1'b0;
      repeat (5) @(negedge clk);
      reg_read(2'd2, v);
      checks++; if (v !== 32'h84) begin errors++; $display("FAIL par_stat: got %h want 84", v); end
      reg_read(2'd0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL par_no_push: got %h want 0", v); end
      reg_write(2'd3, 32'h00);
      par_odd = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_tx();
      logic [31:0] v;
      reg_write(2'd1, 32'h00);
      repeat (30) @(negedge clk);
      checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL midtx_busy: got %b want 0", tx_line); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL midtx_reset: got %b want 1", tx_line); end
      rst = 1'b0;
      repeat (FRAME * DIV + 20) @(negedge clk);
      checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL midtx_stay_idle: got %b want 1", tx_line); end
      reg_read(2'd2, v);
      checks++; if (v !== 32'h04) begin errors++; $display("FAIL midtx_stat: got %h want 04", v); end
   endtask

   initial begin
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_regmap();
      test_tx_frame();
      test_back_to_back();
      test_overrun();
      test_frame_err();
      test_irq();
`ifdef UARTLITE_PARITY_EN
      test_parity();
`endif
      test_reset_mid_tx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
